// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared types and default sizes for the square-wave generator.
//   WAVE_WIDTH    : bit width of one half-period entry (cycles)
//   WAVE_DEPTH    : number of pattern entries (power of two)
//   wave_state_t  : playback FSM states
//   half_period_t : one half-period entry at the default width
package wave_gen_pkg;

   localparam int unsigned WAVE_WIDTH = 10;
   localparam int unsigned WAVE_DEPTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } wave_state_t;

   typedef logic [WAVE_WIDTH-1:0] half_period_t;

endpackage

// File: rtl/wave_gen_timer.sv
// wave_gen_timer: loadable half-period down-counter.
//   Clock    in  : system clock, rising edge
//   nReset   in  : asynchronous active-low reset
//   load     in  : load load_val (clamped to >= 1)
//   clear    in  : force the count to zero (playback stopped)
//   load_val in  : half-period length in cycles
//   done     out : count is 1, i.e. the current half-period ends this cycle
module wave_gen_timer
   import wave_gen_pkg::*;
#(
   parameter int unsigned WIDTH = WAVE_WIDTH
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (load_val == '0) ? ONE : load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - ONE;
      end
   end

   assign done = (cnt == ONE);

endmodule

// File: rtl/wave_gen.sv
// wave_gen: programmable looping square-wave generator.
//   Clock    in  : system clock, rising edge
//   nReset   in  : asynchronous active-low reset (also clears the pattern buffer)
//   wr_en    in  : pattern buffer write strobe
//   wr_addr  in  : entry index to write
//   wr_data  in  : half-period length in cycles (0 behaves as 1)
//   last_idx in  : index of the final entry in the loop, sampled at start
//   start    in  : begin playback (ignored while running)
//   stop     in  : abort playback (wins over start)
//   one_shot in  : play the sequence once (only with WAVE_GEN_ONESHOT_EN)
//   out_wave out : generated waveform, even entries high, odd entries low
//   busy     out : high while playing
//   wrap     out : one-cycle pulse when the last entry completes
// Optional feature macro: WAVE_GEN_ONESHOT_EN adds the one_shot input.
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int unsigned WIDTH = WAVE_WIDTH,
   parameter int unsigned DEPTH = WAVE_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    last_idx,
   input  logic             start,
   input  logic             stop,
`ifdef WAVE_GEN_ONESHOT_EN
   input  logic             one_shot,
`endif
   output logic             out_wave,
   output logic             busy,
   output logic             wrap
);

   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   logic [WIDTH-1:0] buff [DEPTH];
   wave_state_t      state, state_nx;
   logic [AW-1:0]    idx, idx_nx;
   logic [AW-1:0]    last_q, last_nx;
   logic [AW-1:0]    idx_adv;
   logic             at_last;
   logic             oneshot_q, oneshot_nx;
   logic             out_nx, busy_nx, wrap_nx;
   logic             tmr_load, tmr_clear, tmr_done;
   logic [WIDTH-1:0] tmr_val;

   // Buffer writes are independent of playback; a load in the same cycle
   // sees the pre-write contents.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buff[i] <= '0;
         end
      end else if (wr_en) begin
         buff[wr_addr] <= wr_data;
      end
   end

   wave_gen_timer #(.WIDTH(WIDTH)) u_timer (
      .Clock    (Clock),
      .nReset   (nReset),
      .load     (tmr_load),
      .clear    (tmr_clear),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign at_last = (idx == last_q);
   assign idx_adv = at_last ? '0 : idx + IDX_ONE;

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      last_nx    = last_q;
      oneshot_nx = oneshot_q;
      out_nx     = out_wave;
      busy_nx    = busy;
      wrap_nx    = 1'b0;
      tmr_load   = 1'b0;
      tmr_clear  = 1'b0;
      tmr_val    = buff[0];

      unique case (state)
         IDLE: begin
            out_nx  = 1'b0;
            busy_nx = 1'b0;
            if (start && !stop) begin
               state_nx = RUN;
               idx_nx   = '0;
               last_nx  = last_idx;
               tmr_load = 1'b1;
               tmr_val  = buff[0];
               out_nx   = 1'b1;
               busy_nx  = 1'b1;
`ifdef WAVE_GEN_ONESHOT_EN
               oneshot_nx = one_shot;
`else
               oneshot_nx = 1'b0;
`endif
            end
         end
         RUN: begin
            if (stop) begin
               state_nx  = IDLE;
               idx_nx    = '0;
               tmr_clear = 1'b1;
               out_nx    = 1'b0;
               busy_nx   = 1'b0;
            end else if (tmr_done) begin
               wrap_nx = at_last;
               if (oneshot_q && at_last) begin
                  state_nx  = IDLE;
                  idx_nx    = '0;
                  tmr_clear = 1'b1;
                  out_nx    = 1'b0;
                  busy_nx   = 1'b0;
               end else begin
                  idx_nx   = idx_adv;
                  tmr_load = 1'b1;
                  tmr_val  = buff[idx_adv];
                  out_nx   = ~idx_adv[0];
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         idx       <= '0;
         last_q    <= '0;
         oneshot_q <= 1'b0;
         out_wave  <= 1'b0;
         busy      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         last_q    <= last_nx;
         oneshot_q <= oneshot_nx;
         out_wave  <= out_nx;
         busy      <= busy_nx;
         wrap      <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed self-checking bench for wave_gen.
// Build with WAVE_GEN_ONESHOT_EN defined to include the one-shot case.
module tb_wave_gen;

   logic       Clock = 1'b0;
   logic       nReset = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [9:0] wr_data = '0;
   logic [2:0] last_idx = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
`ifdef WAVE_GEN_ONESHOT_EN
   logic       one_shot = 1'b0;
`endif
   logic       out_wave, busy, wrap;

   int n_tests = 0;
   int n_fail  = 0;

   wave_gen #(.WIDTH(10), .DEPTH(8)) dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .last_idx (last_idx),
      .start    (start),
      .stop     (stop),
`ifdef WAVE_GEN_ONESHOT_EN
      .one_shot (one_shot),
`endif
      .out_wave (out_wave),
      .busy     (busy),
      .wrap     (wrap)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = 10'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start(input int last);
      last_idx = 3'(last);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic do_stop(input string tag);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_out"},  int'(out_wave), 0);
      chk({tag, "_wrap"}, int'(wrap), 0);
   endtask

   // Checks the current level, then counts samples until the level changes.
   task automatic phase(input string tag, input int lvl, input int len_exp);
      int len;
      chk({tag, "_lvl"}, int'(out_wave), lvl);
      len = 0;
      while (int'(out_wave) == lvl && len < 200) begin
         len++;
         tick();
      end
      chk({tag, "_len"}, len, len_exp);
   endtask

   initial begin
      int n;

      // Reset and idle
      tick();
      tick();
      nReset = 1'b1;
      chk("rst_out", int'(out_wave), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_wrap", int'(wrap), 0);
      tick();
      chk("idle_busy", int'(busy), 0);

      // All-zero buffer plays as 1-cycle entries
      pulse_start(7);
      for (int k = 0; k < 8; k++) begin
         chk("zero_out", int'(out_wave), (k % 2 == 0) ? 1 : 0);
         chk("zero_wrap", int'(wrap), 0);
         tick();
      end
      chk("zero_wrap_end", int'(wrap), 1);
      chk("zero_out_end", int'(out_wave), 1);
      do_stop("zero_stop");

      // Looping pattern
      wr(0, 10); wr(1, 10); wr(2, 8); wr(3, 8); wr(4, 11); wr(5, 11);
      pulse_start(5);
      chk("loop_busy", int'(busy), 1);
      phase("loop_e0", 1, 10);
      phase("loop_e1", 0, 10);
      phase("loop_e2", 1, 8);
      phase("loop_e3", 0, 8);
      phase("loop_e4", 1, 11);
      phase("loop_e5", 0, 11);
      phase("loop_e0b", 1, 10);
      n = 0;
      while (!wrap && n < 200) begin
         n++;
         tick();
      end
      chk("loop_wrap_seen", int'(wrap), 1);
      n = 0;
      do begin
         n++;
         tick();
      end while (!wrap && n < 200);
      chk("loop_wrap_period", n, 58);
      do_stop("loop_stop");

      // Merged high phase with even last_idx
      wr(0, 4); wr(1, 4); wr(2, 4);
      pulse_start(2);
      phase("mrg_a", 1, 4);
      phase("mrg_b", 0, 4);
      phase("mrg_c", 1, 8);
      phase("mrg_d", 0, 4);
      phase("mrg_e", 1, 8);
      do_stop("mrg_stop");

      // Zero entry yields a one-cycle low phase
      wr(1, 0);
      pulse_start(2);
      phase("z1_a", 1, 4);
      phase("z1_b", 0, 1);
      phase("z1_c", 1, 8);
      do_stop("z1_stop");

      // Stop mid-entry
      pulse_start(2);
      tick();
      tick();
      chk("mid_busy", int'(busy), 1);
      do_stop("mid_stop");

      // start and stop together: stays idle
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", int'(busy), 0);
      chk("ss_out", int'(out_wave), 0);
      tick();
      chk("ss_busy2", int'(busy), 0);

      // start while running does not restart
      wr(1, 4);
      last_idx = 3'd2;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      phase("rs_a", 1, 3);
      phase("rs_b", 0, 4);
      do_stop("rs_stop");

      // Live rewrite during entry 0
      wr(0, 6); wr(1, 2);
      pulse_start(1);
      wr(1, 3);
      wr(0, 9);
      phase("lw_a", 1, 4);
      phase("lw_b", 0, 3);
      phase("lw_c", 1, 9);

      // Async reset mid-run
      tick();
      #1 nReset = 1'b0;
      #1;
      chk("ar_out", int'(out_wave), 0);
      chk("ar_busy", int'(busy), 0);
      tick();
      nReset = 1'b1;
      pulse_start(1);
      phase("ar_clr_a", 1, 1);
      phase("ar_clr_b", 0, 1);
      do_stop("ar_stop");

`ifdef WAVE_GEN_ONESHOT_EN
      wr(0, 5); wr(1, 5);
      one_shot = 1'b1;
      pulse_start(1);
      one_shot = 1'b0;
      phase("os_hi", 1, 5);
      chk("os_lo_busy", int'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
      end
      chk("os_lo_out", int'(out_wave), 0);
      chk("os_lo_busy2", int'(busy), 1);
      tick();
      chk("os_wrap", int'(wrap), 1);
      chk("os_busy", int'(busy), 0);
      chk("os_out", int'(out_wave), 0);
      tick();
      chk("os_wrap_end", int'(wrap), 0);
      chk("os_idle", int'(busy), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wave_gen.md
# wave_gen

Programmable square-wave generator for the frequency-measurement path: the transmit-side counterpart of `freq_counter`. Plays a looping sequence of up to 8 half-period durations, each counted in `Clock` cycles, on `out_wave`. With the 1 MHz system clock it produces the test waveforms `freq_counter` measures on silicon and in simulation. Programmed through a simple write port, then started and stopped by single-cycle strobes.

## Interface
- `WIDTH`, 10: width of one half-period entry, in `Clock` cycles.
- `DEPTH`, 8: number of pattern entries; must be a power of two.
- `Clock` in 1: system clock, rising-edge active.
- `nReset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe for the pattern buffer.
- `wr_addr` in log2(DEPTH): entry index to write.
- `wr_data` in WIDTH: half-period length in cycles; 0 is treated as 1.
- `last_idx` in log2(DEPTH): index of the final entry in the loop; sampled at start.
- `start` in 1: begin playback; ignored while running.
- `stop` in 1: abort playback.
- `out_wave` out 1: generated waveform.
- `busy` out 1: high while in RUN.
- `wrap` out 1: one-cycle pulse when the last entry completes.

## Operation
- Storage: `buff[DEPTH]` of WIDTH bits, plus a captured copy of `last_idx`.
- Two-state FSM:
  - IDLE → RUN on `start` && !`stop`.
  - RUN → IDLE on `stop`, or (one-shot only, see Configuration) on completion of the last entry.
- Entering RUN:
  - `idx` ← 0, `cnt` ← max(`buff[0]`,1), `last_idx` captured.
- In RUN, each cycle:
  - `cnt` decrements.
  - When `cnt`==1: `idx` ← (`idx`==`last_idx`) ? 0 : `idx`+1, and `cnt` reloads from the new entry.
- Output polarity:
  - `out_wave` = ~`idx[0]` in RUN; even entries are high, odd entries are low.
  - In IDLE, `out_wave` = 0.
  - An even `last_idx` makes entry `last_idx` and entry 0 merge into one longer high phase. This is legal and intended.
- `wrap` pulses on the same edge at which `idx` returns from `last_idx` to 0.
- Writes:
  - Accepted in any state.
  - A write to an entry not yet loaded is used when that entry is next loaded.
  - The currently counting entry is unaffected.
- Counter arithmetic: unsigned WIDTH bits; no overflow is possible because it only loads and decrements.

## Timing
- Reset values:
  - `out_wave`=0, `busy`=0, `wrap`=0.
  - FSM=IDLE, `idx`=0, `cnt`=0.
  - All `buff` entries = 0.
- Start latency: `start` sampled at edge N; `busy` and `out_wave` are 1 after edge N (registered outputs).
- Duration: entry k holds its level for exactly max(`buff[k]`,1) cycles.
- Stop:
  - `stop` sampled at edge N; `out_wave`=0 and `busy`=0 after edge N.
  - `wrap` is suppressed in that cycle.
- `start` and `stop` in the same cycle: `stop` wins and the FSM stays or returns to IDLE.
- A write to the same address as an entry being loaded in the same cycle loads the old value.
- `nReset` asserted mid-run: all outputs drop immediately (asynchronous) and the buffer clears.

## Configuration
- `WAVE_GEN_ONESHOT_EN` defined:
  - Adds input port `one_shot` (1 bit), sampled with `start`.
  - When it is captured high, the sequence plays once. After the last entry completes, `wrap` pulses and the FSM returns to IDLE on the same edge, so `out_wave`=0 and `busy`=0.
- `WAVE_GEN_ONESHOT_EN` undefined:
  - No `one_shot` port.
  - Playback always loops until `stop`.

## Structure
- Package `wave_gen_pkg` holds:
  - `WAVE_WIDTH`=10 and `WAVE_DEPTH`=8.
  - The `wave_state_t` enum {IDLE, RUN}.
  - The `half_period_t` typedef, `logic [WAVE_WIDTH-1:0]`.
- Sub-module `wave_gen_timer`:
  - Loadable down-counter with load value clamped to ≥1.
  - Outputs a `done` flag when the count is 1.
- The top level holds the buffer, the FSM and the output registers.

## Test plan
- Reset then idle: `nReset` low 2 cycles, then high → `out_wave`=0, `busy`=0, `wrap`=0, and all entries read back as zero by playing them.
- Looping pattern: `buff`={10,10,8,8,11,11}, `last_idx`=5, then `start` → high 10, low 10, high 8, low 8, high 11, low 11 cycles, repeating. `wrap` pulses every 58 cycles.
- Merged phase: `buff`={4,4,4}, `last_idx`=2 → high 4, low 4, then high 8 per loop after the first. Zero-entry case: `buff[1]`=0 gives a low phase of 1 cycle.
- Stop handling:
  - `stop` mid-entry → `out_wave`=0 and `busy`=0 on the next edge.
  - `start` and `stop` in the same cycle → stays IDLE.
  - `start` while running → no effect on the waveform.
- Live rewrite: during entry 0, write `buff[1]`=3 → the following low phase lasts 3 cycles. Rewriting `buff[0]` mid-entry does not change the current entry.
- One-shot (macro defined, `one_shot`=1, `buff`={5,5}, `last_idx`=1) → high 5, low 5, then `wrap` pulses and IDLE follows. Async reset mid-run → `out_wave` drops to 0 without waiting for a clock edge.
